// File: rtl/d_sram_like_bridge.sv
// d_sram_like_bridge: converts the CPU data SRAM port into one transaction
// at a time on a split address/data sram-like bus (req/addr_ok/data_ok).
// d_stall holds the M stage until the bus transaction has completed.
module d_sram_like_bridge #(
    parameter bit ADDR_MAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    // CPU data SRAM side
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        d_stall,
    // sram-like bus side
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        cap_rdata_s;
    logic        start_s;
    logic [4:0]  enc_s;
    logic [31:0] phys_addr_s;

    logic        req_r;
    logic        wr_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;

    // Byte enables -> {wr, size[1:0], addr[1:0]}; odd patterns degrade to a word write.
    function automatic logic [4:0] enc_wen(input logic [3:0] wen);
        logic [4:0] res;
        case (wen)
            4'b0000: res = {1'b0, 2'd2, 2'b00};
            4'b1111: res = {1'b1, 2'd2, 2'b00};
            4'b0011: res = {1'b1, 2'd1, 2'b00};
            4'b1100: res = {1'b1, 2'd1, 2'b10};
            4'b0001: res = {1'b1, 2'd0, 2'b00};
            4'b0010: res = {1'b1, 2'd0, 2'b01};
            4'b0100: res = {1'b1, 2'd0, 2'b10};
            4'b1000: res = {1'b1, 2'd0, 2'b11};
            default: res = {1'b1, 2'd2, 2'b00};
        endcase
        return res;
    endfunction

    assign enc_s       = enc_wen(data_sram_wen);
    assign phys_addr_s = ADDR_MAP_EN ? (data_sram_addr & 32'h1FFF_FFFF) : data_sram_addr;
    assign start_s     = (state_r == ST_IDLE) && data_sram_en;

    // Next-state logic and read-data capture strobe.
    always_comb begin
        state_next_s = state_r;
        cap_rdata_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (data_sram_en) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (addr_ok && data_ok) begin
                    state_next_s = ST_DONE;
                    cap_rdata_s  = ~wr_r;
                end else if (addr_ok) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (data_ok) begin
                    state_next_s = ST_DONE;
                    cap_rdata_s  = ~wr_r;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register, registered bus request fields and returned read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            wr_r    <= 1'b0;
            size_r  <= 2'd0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            req_r   <= (state_next_s == ST_REQ);
            if (start_s) begin
                wr_r    <= enc_s[4];
                size_r  <= enc_s[3:2];
                addr_r  <= {phys_addr_s[31:2], enc_s[1:0]};
                wdata_r <= data_sram_wdata;
            end
            if (cap_rdata_s) begin
                rdata_r <= rdata;
            end
        end
    end

    // Stall is combinational so the CPU is held in the very cycle en rises.
    assign d_stall         = data_sram_en & (state_r != ST_DONE);
    assign req             = req_r;
    assign wr              = wr_r;
    assign size            = size_r;
    assign addr            = addr_r;
    assign wdata           = wdata_r;
    assign data_sram_rdata = rdata_r;

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Directed bench for d_sram_like_bridge; a second instance with the address
// fold disabled shares all inputs.
module tb_d_sram_like_bridge;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] caddr;
    logic [31:0] cwdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] brdata;

    logic [31:0] m_rdata, u_rdata;
    logic        m_stall, u_stall;
    logic        m_req, u_req;
    logic        m_wr, u_wr;
    logic [1:0]  m_size, u_size;
    logic [31:0] m_addr, u_addr;
    logic [31:0] m_wdata, u_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    d_sram_like_bridge #(.ADDR_MAP_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(caddr),
        .data_sram_wdata(cwdata), .data_sram_rdata(m_rdata), .d_stall(m_stall),
        .req(m_req), .wr(m_wr), .size(m_size), .addr(m_addr), .wdata(m_wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(brdata)
    );

    d_sram_like_bridge #(.ADDR_MAP_EN(1'b0)) dut_nomap (
        .clk(clk), .rst(rst),
        .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(caddr),
        .data_sram_wdata(cwdata), .data_sram_rdata(u_rdata), .d_stall(u_stall),
        .req(u_req), .wr(u_wr), .size(u_size), .addr(u_addr), .wdata(u_wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(brdata)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        rst = 1'b1; en = 1'b0; wen = 4'b0000; caddr = 32'h0; cwdata = 32'h0;
        addr_ok = 1'b0; data_ok = 1'b0; brdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_req",   {31'd0, m_req},   32'd0);
        chk("rst_wr",    {31'd0, m_wr},    32'd0);
        chk("rst_size",  {30'd0, m_size},  32'd0);
        chk("rst_addr",  m_addr,           32'h0);
        chk("rst_wdata", m_wdata,          32'h0);
        chk("rst_rdata", m_rdata,          32'h0);
        chk("rst_stall", {31'd0, m_stall}, 32'd0);

        // Read, fixed latency
        en = 1'b1; wen = 4'b0000; caddr = 32'hBFC0_0010; #1;
        chk("rd_idle_stall", {31'd0, m_stall}, 32'd1);
        chk("rd_idle_req",   {31'd0, m_req},   32'd0);
        tick();                                  // REQ
        addr_ok = 1'b1; #1;
        chk("rd_req",        {31'd0, m_req},   32'd1);
        chk("rd_addr",       m_addr,           32'h1FC0_0010);
        chk("rd_size",       {30'd0, m_size},  32'd2);
        chk("rd_wr",         {31'd0, m_wr},    32'd0);
        chk("rd_req_stall",  {31'd0, m_stall}, 32'd1);
        tick();                                  // WAIT
        addr_ok = 1'b0; #1;
        chk("rd_wait_req",   {31'd0, m_req},   32'd0);
        chk("rd_wait_stall", {31'd0, m_stall}, 32'd1);
        tick();                                  // WAIT, response arrives
        data_ok = 1'b1; brdata = 32'h1234_5678; #1;
        chk("rd_wait2_stall", {31'd0, m_stall}, 32'd1);
        tick();                                  // DONE
        data_ok = 1'b0; #1;
        chk("rd_done_stall", {31'd0, m_stall}, 32'd0);
        chk("rd_done_rdata", m_rdata,          32'h1234_5678);
        en = 1'b0;
        tick();                                  // IDLE
        chk("rd_idle_after", {31'd0, m_stall}, 32'd0);

        // Byte write
        en = 1'b1; wen = 4'b0100; caddr = 32'h8000_0001; cwdata = 32'h00AB_0000;
        tick();                                  // REQ
        addr_ok = 1'b1; #1;
        chk("bw_wr",    {31'd0, m_wr},   32'd1);
        chk("bw_size",  {30'd0, m_size}, 32'd0);
        chk("bw_addr",  m_addr,          32'h0000_0002);
        chk("bw_wdata", m_wdata,         32'h00AB_0000);
        tick();                                  // WAIT
        addr_ok = 1'b0; data_ok = 1'b1; brdata = 32'hDEAD_BEEF; #1;
        tick();                                  // DONE
        data_ok = 1'b0; #1;
        chk("bw_done_stall", {31'd0, m_stall}, 32'd0);
        chk("bw_rdata_kept", m_rdata,          32'h1234_5678);
        en = 1'b0;
        tick();

        // Half write with addr_ok held low for 5 cycles
        en = 1'b1; wen = 4'b1100; caddr = 32'h8000_0102; cwdata = 32'hCAFE_0000;
        tick();                                  // REQ
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hw_bp_req",   {31'd0, m_req},   32'd1);
            chk("hw_bp_addr",  m_addr,           32'h0000_0102);
            chk("hw_bp_size",  {30'd0, m_size},  32'd1);
            chk("hw_bp_wdata", m_wdata,          32'hCAFE_0000);
            chk("hw_bp_stall", {31'd0, m_stall}, 32'd1);
            tick();
        end
        addr_ok = 1'b1; data_ok = 1'b1; brdata = 32'hFFFF_FFFF; #1;
        chk("hw_hs_stall", {31'd0, m_stall}, 32'd1);
        tick();                                  // DONE
        addr_ok = 1'b0; data_ok = 1'b0; #1;
        chk("hw_done_stall", {31'd0, m_stall}, 32'd0);
        chk("hw_rdata_kept", m_rdata,          32'h1234_5678);
        en = 1'b0;
        tick();

        // Same-cycle addr_ok/data_ok, then back-to-back read
        en = 1'b1; wen = 4'b0000; caddr = 32'hA000_0040; #1;
        chk("sc_idle_stall", {31'd0, m_stall}, 32'd1);
        tick();                                  // REQ
        addr_ok = 1'b1; data_ok = 1'b1; brdata = 32'h1122_3344; #1;
        chk("sc_req",       {31'd0, m_req},   32'd1);
        chk("sc_req_stall", {31'd0, m_stall}, 32'd1);
        tick();                                  // DONE after 2 stall cycles
        addr_ok = 1'b0; data_ok = 1'b0; caddr = 32'h0000_0080; #1;
        chk("sc_done_stall", {31'd0, m_stall}, 32'd0);
        chk("sc_done_rdata", m_rdata,          32'h1122_3344);
        chk("sc_done_req",   {31'd0, m_req},   32'd0);
        tick();                                  // IDLE, en still high
        chk("b2b_idle_stall", {31'd0, m_stall}, 32'd1);
        chk("b2b_idle_req",   {31'd0, m_req},   32'd0);
        tick();                                  // REQ
        chk("b2b_req",  {31'd0, m_req}, 32'd1);
        chk("b2b_addr", m_addr,         32'h0000_0080);
        addr_ok = 1'b1;
        tick();                                  // WAIT
        addr_ok = 1'b0; data_ok = 1'b1; brdata = 32'h5566_7788;
        tick();                                  // DONE
        data_ok = 1'b0; #1;
        chk("b2b_done_stall", {31'd0, m_stall}, 32'd0);
        chk("b2b_done_rdata", m_rdata,          32'h5566_7788);
        en = 1'b0;
        tick();

        // Reset during WAIT, then stray data_ok
        en = 1'b1; wen = 4'b0000; caddr = 32'h0000_0040;
        tick();                                  // REQ
        addr_ok = 1'b1;
        tick();                                  // WAIT
        addr_ok = 1'b0; rst = 1'b1; en = 1'b0;
        tick();                                  // reset -> IDLE
        rst = 1'b0; data_ok = 1'b1; brdata = 32'h9999_9999; #1;
        chk("rstw_req",   {31'd0, m_req},   32'd0);
        chk("rstw_stall", {31'd0, m_stall}, 32'd0);
        chk("rstw_rdata", m_rdata,          32'h0);
        tick();
        data_ok = 1'b0; #1;
        chk("stray_rdata", m_rdata,        32'h0);
        chk("stray_req",   {31'd0, m_req}, 32'd0);

        // Address fold disabled vs enabled
        en = 1'b1; wen = 4'b0000; caddr = 32'hBFC0_0000;
        tick();                                  // REQ
        chk("nomap_addr", u_addr, 32'hBFC0_0000);
        chk("map_addr",   m_addr, 32'h1FC0_0000);
        addr_ok = 1'b1; data_ok = 1'b1; brdata = 32'h0BAD_F00D;
        tick();                                  // DONE
        addr_ok = 1'b0; data_ok = 1'b0; #1;
        chk("nomap_rdata", u_rdata, 32'h0BAD_F00D);
        en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
